uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmitter between the metadata sender and the sample-FIFO readout path, replacing the static data/meta transmit mux. Each requester offers bytes on a valid/ready handshake. The arbiter grants one requester at a time, with packet locking via a `last` flag. It pulses the transmitter, tracks `tx_busy` through each byte, and flags a transmitter that never goes busy.

## Interface
Parameters:
- SAMPLE_WIDTH, 8, width of sample bytes; must be ≤ 8, zero-extended onto the 8-bit UART byte.
- BUSY_TIMEOUT, 16, cycles to wait for `tx_busy` to rise after `trans_en`; range 2..255.

Ports (one clock; reset is synchronous and active-low):
- clock  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- meta_valid  in  1  metadata byte offered; held until accepted.
- meta_data  in  8  metadata byte.
- meta_last  in  1  final byte of a metadata packet.
- meta_ready  out  1  metadata byte accepted this cycle.
- smp_valid  in  1  sample byte offered; held until accepted.
- smp_data  in  SAMPLE_WIDTH  sample byte.
- smp_last  in  1  final byte of a sample burst.
- smp_ready  out  1  sample byte accepted this cycle.
- tx_busy  in  1  UART transmitter busy.
- trans_en  out  1  one-cycle transmit strobe to the UART.
- tran_data  out  8  byte to the UART.
- grant  out  2  one-hot current/last owner: bit0 = meta, bit1 = sample.
- idle  out  1  state is IDLE, no lock held, and `tx_busy` is low.
- timeout_err  out  1  sticky watchdog error.
- byte_count  out  16  bytes completed; wraps at 0xFFFF→0.
- clear_stats  in  1  clears `timeout_err` and `byte_count`.

## Operation
- States: IDLE, FIRE, WAIT_RISE, WAIT_FALL.
- IDLE, arbitration when `tx_busy` = 0:
  - If a lock is held, only the locked owner is eligible.
  - Otherwise meta has fixed priority over sample.
- IDLE, acceptance:
  - If the eligible requester's valid is high, assert its ready in the same cycle (combinational from state, lock and valids).
  - Register its byte into `tran_data`, update `grant`, and go to FIRE.
- IDLE with `tx_busy` = 1: accept nothing.
- Lock rules:
  - Accepting a byte with last = 0 sets lock to that owner.
  - Accepting a byte with last = 1 clears the lock.
  - While locked, the other requester waits even if valid.
- FIRE: `trans_en` = 1 for exactly one cycle; clear the watchdog timer; go to WAIT_RISE.
- WAIT_RISE:
  - `tx_busy` = 1 → WAIT_FALL.
  - Otherwise increment the timer. At timer = BUSY_TIMEOUT−1, set `timeout_err`, increment `byte_count`, go to IDLE. The byte is dropped; lock state is unchanged.
- WAIT_FALL: `tx_busy` = 0 → increment `byte_count`, go to IDLE.
- `clear_stats` in the same cycle as a count increment: clear wins.
- Reset mid-operation: state → IDLE, lock cleared, byte in flight abandoned (no `trans_en` in the reset cycle or the cycle after).

## Timing
- Reset values:
  - `trans_en` = 0, `tran_data` = 0x00, `grant` = 2'b00.
  - `meta_ready` = `smp_ready` = 0.
  - `timeout_err` = 0, `byte_count` = 0.
  - `idle` = 1 whenever `tx_busy` = 0.
- Ready in cycle N → `trans_en` and the new `tran_data` in cycle N+1.
- `tran_data` is stable from N+1 until the next accept.
- Earliest next ready: 2 cycles after `tx_busy` falls.
- Minimum byte period: 4 cycles plus the UART busy time.
- Ready pulses are at most one cycle long and never both high in the same cycle.

## Structure
- Shared package `acsp_pkg`:
  - `arb_state_t` enum (IDLE, FIRE, WAIT_RISE, WAIT_FALL).
  - `tx_src_t` enum (SRC_META, SRC_SMP).
  - UART byte width constant (8).
- Natural sub-module: `tx_busy_watchdog`, the timer plus sticky error flag, with start, stop and clear inputs.

## Test plan
- Single meta byte 0xA5 with last = 1, UART busy for 10 cycles → `meta_ready` in cycle N; `trans_en` and `tran_data` = 0xA5 in N+1; `byte_count` = 1; `idle` = 1 after `tx_busy` falls.
- Meta and sample both valid in IDLE → meta accepted first. Sample is accepted 2 cycles after meta's `tx_busy` falls, with `grant` = 2'b10.
- Meta packet 0x01, 0x02, 0x03 (last on 0x03) while sample valid throughout → all three meta bytes go out consecutively before any `smp_ready`.
- Sample burst locked (last = 0), then meta becomes valid → meta waits until the sample byte with last = 1 completes.
- `tx_busy` held low after `trans_en`, BUSY_TIMEOUT = 16 → `timeout_err` = 1 exactly 16 cycles after FIRE and `byte_count` increments. A following `clear_stats` zeroes both.
- `reset_n` low during WAIT_FALL with a lock held → next cycle: IDLE, no lock, counters zero, no `trans_en`. Fresh arbitration then proceeds by priority.

Source files
------------

// File: rtl/acsp_pkg.sv
// Shared types and constants for the acquisition/control serial path.
package acsp_pkg;

    localparam int UART_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        WAIT_RISE,
        WAIT_FALL
    } arb_state_t;

    typedef enum logic {
        SRC_META,
        SRC_SMP
    } tx_src_t;

    // One-hot grant encoding: bit0 = meta, bit1 = sample.
    function automatic logic [1:0] src_onehot(input tx_src_t src);
        return (src == SRC_META) ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/tx_busy_watchdog.sv
// Watchdog for a UART transmitter that never raises tx_busy after a strobe.
// start arms and zeroes the timer, stop disarms it once busy has been seen,
// clear drops the sticky error flag.
module tx_busy_watchdog #(
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    input  logic stop,
    input  logic clear,
    output logic expired,
    output logic timeout_err
);

    localparam logic [7:0] LIMIT = 8'(BUSY_TIMEOUT - 1);

    logic       armed;
    logic [7:0] timer;
    logic [7:0] timer_nxt;

    // The timer is compared after its increment, so expiry lands on the
    // cycle whose incremented value reaches BUSY_TIMEOUT-1.
    assign timer_nxt = timer + 8'd1;
    assign expired   = armed && !stop && (timer_nxt == LIMIT);

    // Timer: zeroed on start, counts while armed, disarms on stop or expiry.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            armed <= 1'b0;
            timer <= '0;
        end else if (start) begin
            armed <= 1'b1;
            timer <= '0;
        end else if (armed) begin
            if (stop || expired) begin
                armed <= 1'b0;
            end else begin
                timer <= timer_nxt;
            end
        end
    end

    // Sticky error flag; an explicit clear beats a simultaneous expiry.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            timeout_err <= 1'b0;
        end else if (clear) begin
            timeout_err <= 1'b0;
        end else if (expired) begin
            timeout_err <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between the metadata sender and the sample
// FIFO readout. Meta has fixed priority unless a packet lock is held; a
// byte accepted with last=0 locks the arbiter to its owner until last=1.
module uart_tx_arbiter
    import acsp_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    meta_valid,
    input  logic [UART_W-1:0]       meta_data,
    input  logic                    meta_last,
    output logic                    meta_ready,
    input  logic                    smp_valid,
    input  logic [SAMPLE_WIDTH-1:0] smp_data,
    input  logic                    smp_last,
    output logic                    smp_ready,
    input  logic                    tx_busy,
    output logic                    trans_en,
    output logic [UART_W-1:0]       tran_data,
    output logic [1:0]              grant,
    output logic                    idle,
    output logic                    timeout_err,
    output logic [15:0]             byte_count,
    input  logic                    clear_stats
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              busy_p0;
    logic              lock_vld;
    tx_src_t           lock_src;
    logic              meta_elig;
    logic              smp_elig;
    logic              accept;
    tx_src_t           acc_src;
    logic              acc_last;
    logic [UART_W-1:0] acc_byte;
    logic [UART_W-1:0] smp_byte;
    logic              wd_start;
    logic              wd_stop;
    logic              wd_expired;
    logic              byte_done;

    // Sample bytes narrower than the UART byte are zero-extended.
    always_comb begin
        smp_byte                   = '0;
        smp_byte[SAMPLE_WIDTH-1:0] = smp_data;
    end

    // Eligibility: the lock owner only, otherwise meta before sample.
    assign meta_elig = !lock_vld || (lock_src == SRC_META);
    assign smp_elig  = lock_vld ? (lock_src == SRC_SMP) : !meta_valid;

    assign accept   = meta_ready || smp_ready;
    assign acc_src  = meta_ready ? SRC_META : SRC_SMP;
    assign acc_last = meta_ready ? meta_last : smp_last;
    assign acc_byte = meta_ready ? meta_data : smp_byte;

    assign wd_start  = (state == FIRE);
    assign wd_stop   = (state == WAIT_RISE) && busy_p0;
    assign byte_done = ((state == WAIT_FALL) && !busy_p0) || wd_expired;

    // tx_busy is registered once; the FSM tracks busy through this copy,
    // which sets the two-cycle gap between busy falling and the next ready.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy_p0 <= 1'b0;
        end else begin
            busy_p0 <= tx_busy;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept)          state_nxt = FIRE;
            FIRE:                           state_nxt = WAIT_RISE;
            WAIT_RISE: if (busy_p0)         state_nxt = WAIT_FALL;
                       else if (wd_expired) state_nxt = IDLE;
            WAIT_FALL: if (!busy_p0)        state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // FSM outputs; ready and strobe are forced low while reset is asserted
    // so an in-flight byte is never strobed during the reset cycle.
    always_comb begin
        meta_ready = reset_n && (state == IDLE) && !tx_busy && !busy_p0
                     && meta_elig && meta_valid;
        smp_ready  = reset_n && (state == IDLE) && !tx_busy && !busy_p0
                     && smp_elig && smp_valid;
        trans_en   = reset_n && (state == FIRE);
        idle       = (state == IDLE) && !lock_vld && !tx_busy;
    end

    // Accepted byte and owner are held until the next acceptance.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tran_data <= '0;
            grant     <= 2'b00;
        end else if (accept) begin
            tran_data <= acc_byte;
            grant     <= src_onehot(acc_src);
        end
    end

    // Packet lock: last=0 locks to the owner, last=1 releases it.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lock_vld <= 1'b0;
            lock_src <= SRC_META;
        end else if (accept) begin
            lock_vld <= !acc_last;
            lock_src <= acc_src;
        end
    end

    // Completed-byte counter, including bytes dropped on watchdog expiry.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            byte_count <= '0;
        end else if (clear_stats) begin
            byte_count <= '0;
        end else if (byte_done) begin
            byte_count <= byte_count + 16'd1;
        end
    end

    tx_busy_watchdog #(
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) u_watchdog (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (wd_start),
        .stop        (wd_stop),
        .clear       (clear_stats),
        .expired     (wd_expired),
        .timeout_err (timeout_err)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester drivers, a UART busy
// model, and a monitor that pops expected bytes on every trans_en.
module tb_uart_tx_arbiter;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } req_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] grant;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        meta_valid;
    logic [7:0]  meta_data;
    logic        meta_last;
    logic        meta_ready;
    logic        smp_valid;
    logic [7:0]  smp_data;
    logic        smp_last;
    logic        smp_ready;
    logic        tx_busy;
    logic        trans_en;
    logic [7:0]  tran_data;
    logic [1:0]  grant;
    logic        idle;
    logic        timeout_err;
    logic [15:0] byte_count;
    logic        clear_stats;

    req_t meta_q[$];
    req_t smp_q[$];
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    int te_cyc  = 0;
    int fall_cyc = 0;
    int smp_gap = 0;
    int smp_acc_n = 0;
    logic meta_rdy_seen = 1'b0;
    logic smp_rdy_seen  = 1'b0;
    logic prev_te   = 1'b0;
    logic prev_busy = 1'b0;
    logic uart_mute = 1'b0;
    int   busy_len  = 10;

    uart_tx_arbiter #(
        .SAMPLE_WIDTH (8),
        .BUSY_TIMEOUT (16)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .meta_valid  (meta_valid),
        .meta_data   (meta_data),
        .meta_last   (meta_last),
        .meta_ready  (meta_ready),
        .smp_valid   (smp_valid),
        .smp_data    (smp_data),
        .smp_last    (smp_last),
        .smp_ready   (smp_ready),
        .tx_busy     (tx_busy),
        .trans_en    (trans_en),
        .tran_data   (tran_data),
        .grant       (grant),
        .idle        (idle),
        .timeout_err (timeout_err),
        .byte_count  (byte_count),
        .clear_stats (clear_stats)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_req(input bit is_meta, input logic [7:0] d, input logic l);
        req_t r;
        r.data = d;
        r.last = l;
        if (is_meta) meta_q.push_back(r);
        else         smp_q.push_back(r);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [1:0] g);
        exp_t e;
        e.data  = d;
        e.grant = g;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int  n = 0;
        bit  ok = 0;
        while (!ok && n < budget) begin
            @(negedge clock);
            n++;
            ok = (exp_q.size() == 0) && (meta_q.size() == 0) && (smp_q.size() == 0)
                 && !meta_valid && !smp_valid && (idle === 1'b1);
        end
        if (!ok) check_eq(tag, 32'd0, 32'd1);
    endtask

    // Meta requester: holds valid until the DUT accepts, then moves on.
    initial begin
        meta_valid = 1'b0;
        meta_data  = '0;
        meta_last  = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (meta_valid && meta_rdy_seen) meta_valid = 1'b0;
            if (!meta_valid && meta_q.size() > 0) begin
                req_t r;
                r = meta_q.pop_front();
                meta_data  = r.data;
                meta_last  = r.last;
                meta_valid = 1'b1;
            end
        end
    end

    // Sample requester.
    initial begin
        smp_valid = 1'b0;
        smp_data  = '0;
        smp_last  = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (smp_valid && smp_rdy_seen) smp_valid = 1'b0;
            if (!smp_valid && smp_q.size() > 0) begin
                req_t r;
                r = smp_q.pop_front();
                smp_data  = r.data;
                smp_last  = r.last;
                smp_valid = 1'b1;
            end
        end
    end

    // UART model: busy for busy_len cycles starting the cycle after trans_en.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (trans_en === 1'b1 && !uart_mute) begin
                @(posedge clock);
                #1 tx_busy = 1'b1;
                repeat (busy_len) @(posedge clock);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Monitor and scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            meta_rdy_seen = meta_ready;
            smp_rdy_seen  = smp_ready;
            if (meta_ready && smp_ready) check_eq("rdy_excl", {meta_ready, smp_ready}, 32'd1);
            if (meta_ready || smp_ready) acc_cyc = cyc;
            if (smp_ready) begin
                smp_gap = cyc - fall_cyc;
                smp_acc_n++;
            end
            if (trans_en === 1'b1) begin
                check_eq("te_width", prev_te, 32'd0);
                check_eq("te_lat", cyc - acc_cyc, 32'd1);
                te_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check_eq("sb_extra", tran_data, 32'hFFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("sb_data", tran_data, e.data);
                    check_eq("sb_grant", grant, e.grant);
                end
            end
            if (!tx_busy && prev_busy) fall_cyc = cyc;
            prev_te   = trans_en;
            prev_busy = tx_busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        int err_cyc;
        reset_n     = 1'b0;
        clear_stats = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_te", trans_en, 32'd0);
        check_eq("rst_data", tran_data, 32'h00);
        check_eq("rst_grant", grant, 32'd0);
        check_eq("rst_rdy", {meta_ready, smp_ready}, 32'd0);
        check_eq("rst_err", timeout_err, 32'd0);
        check_eq("rst_cnt", byte_count, 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check_eq("rst_idle", idle, 32'd1);

        // Single meta byte.
        push_exp(8'hA5, 2'b01);
        push_req(1, 8'hA5, 1'b1);
        wait_done("t1_wait", 200);
        check_eq("t1_cnt", byte_count, 32'd1);
        check_eq("t1_idle", idle, 32'd1);

        // Meta and sample together: meta first, sample two cycles after busy falls.
        push_exp(8'h3C, 2'b01);
        push_exp(8'h5A, 2'b10);
        push_req(1, 8'h3C, 1'b1);
        push_req(0, 8'h5A, 1'b1);
        wait_done("t2_wait", 300);
        check_eq("t2_gap", smp_gap, 32'd2);
        check_eq("t2_cnt", byte_count, 32'd3);
        check_eq("t2_grant", grant, 32'b10);

        // Locked meta packet ahead of a waiting sample.
        push_exp(8'h01, 2'b01);
        push_exp(8'h02, 2'b01);
        push_exp(8'h03, 2'b01);
        push_exp(8'h40, 2'b10);
        push_req(1, 8'h01, 1'b0);
        push_req(1, 8'h02, 1'b0);
        push_req(1, 8'h03, 1'b1);
        push_req(0, 8'h40, 1'b1);
        wait_done("t3_wait", 400);
        check_eq("t3_cnt", byte_count, 32'd7);

        // Locked sample burst; meta arrives after the first sample byte.
        push_exp(8'h10, 2'b10);
        push_exp(8'h11, 2'b10);
        push_exp(8'h12, 2'b10);
        push_exp(8'h77, 2'b01);
        base = smp_acc_n;
        push_req(0, 8'h10, 1'b0);
        push_req(0, 8'h11, 1'b0);
        push_req(0, 8'h12, 1'b1);
        n = 0;
        while (smp_acc_n == base && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (smp_acc_n == base) check_eq("t4_first", 32'd0, 32'd1);
        push_req(1, 8'h77, 1'b1);
        wait_done("t4_wait", 400);
        check_eq("t4_cnt", byte_count, 32'd11);

        // Reset during WAIT_FALL with a sample lock held.
        push_exp(8'h21, 2'b10);
        push_req(0, 8'h21, 1'b0);
        n = 0;
        while (tx_busy !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (tx_busy !== 1'b1) check_eq("t6_busy", 32'd0, 32'd1);
        repeat (4) @(negedge clock);
        @(posedge clock);
        #1 reset_n = 1'b0;
        @(negedge clock);
        check_eq("t6_rst_te", trans_en, 32'd0);
        check_eq("t6_rst_rdy", {meta_ready, smp_ready}, 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check_eq("t6_te", trans_en, 32'd0);
        check_eq("t6_cnt", byte_count, 32'd0);
        check_eq("t6_grant", grant, 32'd0);
        check_eq("t6_data", tran_data, 32'd0);
        push_exp(8'h66, 2'b01);
        push_exp(8'h22, 2'b10);
        push_req(1, 8'h66, 1'b1);
        push_req(0, 8'h22, 1'b1);
        wait_done("t6_wait", 400);
        check_eq("t6_cnt2", byte_count, 32'd2);

        // Transmitter never goes busy: watchdog fires, then clear_stats.
        uart_mute = 1'b1;
        push_exp(8'h99, 2'b01);
        push_req(1, 8'h99, 1'b1);
        n = 0;
        while (timeout_err !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        err_cyc = cyc;
        check_eq("t5_err", timeout_err, 32'd1);
        check_eq("t5_lat", err_cyc - te_cyc, 32'd16);
        check_eq("t5_cnt", byte_count, 32'd3);
        check_eq("t5_idle", idle, 32'd1);
        @(posedge clock);
        #1 clear_stats = 1'b1;
        @(posedge clock);
        #1 clear_stats = 1'b0;
        @(negedge clock);
        check_eq("t5_clr_err", timeout_err, 32'd0);
        check_eq("t5_clr_cnt", byte_count, 32'd0);
        check_eq("sb_left", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
